seq_det_prog: RTL and testbench

Parametrised Moore-style serial sequence detector, the generalised successor to the team's fixed 3-bit pattern detectors. It watches a 1-bit serial stream qualified by a valid strobe and matches it against a run-time-loadable N-bit pattern. Overlapping or non-overlapping detection is selected by parameter. It sits between a serial front-end (deserialiser / line decoder) and control logic that consumes a registered detect flag and an optional match count.

---
 rtl/seq_det_prog.sv | 109 ++++++++++
 tb/tb_seq_det_prog.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// seq_det_prog: run-time programmable N-bit serial sequence detector with a registered Moore flag.
// Define SEQ_DET_PROG_COUNT_EN to build the saturating match counter; otherwise det_cnt is tied to 0.
module seq_det_prog #(
    parameter int           N        = 3,
    parameter bit           OVERLAP  = 1'b1,
    parameter logic [N-1:0] PAT_INIT = N'(3'b101),
    parameter int           CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inp,
    input  logic          in_valid,
    input  logic          load,
    input  logic [N-1:0]  pattern,
    output logic          det,
    output logic [CW-1:0] det_cnt
);
    localparam int            FW        = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("seq_det_prog: N must be in 2..16");
    end

    logic [N-1:0]  pat_r;
    logic [N-1:0]  hist;
    logic [FW-1:0] fill;

    logic [N-1:0]  hist_d;
    logic [FW-1:0] fill_d;
    logic          det_d;
    logic          accept;
    logic          match;
    logic [N-1:0]  shifted;

    // Load wins over the data strobe, so a coincident bit is simply dropped.
    assign accept  = in_valid & ~load;
    assign shifted = {hist[N-2:0], inp};
    assign match   = accept && (shifted == pat_r) && (fill >= FILL_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hist_d = hist;
        fill_d = fill;
        det_d  = det;
        if (load) begin
            hist_d = '0;
            fill_d = '0;
            det_d  = 1'b0;
        end else if (accept) begin
            det_d = match;
            if (match && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = shifted;
                fill_d = (fill == FILL_FULL) ? fill : fill + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r <= PAT_INIT;
            hist  <= '0;
            fill  <= '0;
            det   <= 1'b0;
        end else begin
            if (load) begin
                pat_r <= pattern;
            end
            hist <= hist_d;
            fill <= fill_d;
            det  <= det_d;
        end
    end

`ifdef SEQ_DET_PROG_COUNT_EN
    logic [CW-1:0] cnt_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= '0;
        end else if (match && (cnt_r != {CW{1'b1}})) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign det_cnt = cnt_r;
`else
    assign det_cnt = '0;
`endif

    // A raised flag always reflects the history left behind by the matching bit.
    if (OVERLAP) begin : g_chk_overlap
        a_det_hist : assert property (@(posedge clk) disable iff (!rst)
            det |-> (hist == pat_r && fill == FILL_FULL));
    end else begin : g_chk_nonoverlap
        a_det_hist : assert property (@(posedge clk) disable iff (!rst)
            det |-> (hist == '0 && fill == '0));
    end

    a_fill_range : assert property (@(posedge clk) disable iff (!rst) fill <= FILL_FULL);

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed checks of seq_det_prog across four parameterisations sharing one stimulus bus.
// Counter expectations follow SEQ_DET_PROG_COUNT_EN so the bench serves both builds.
module tb_seq_det_prog;

`ifdef SEQ_DET_PROG_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       inp;
    logic       in_valid;
    logic       load;
    logic [2:0] pat3;
    logic [3:0] pat4;
    logic [1:0] pat2;

    logic       det_no, det_ov, det_n4, det_sat;
    logic [7:0] cnt_no, cnt_ov, cnt_n4;
    logic [1:0] cnt_sat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_det_prog #(.N(3), .OVERLAP(1'b0)) u_no (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .load(load),
        .pattern(pat3), .det(det_no), .det_cnt(cnt_no));

    seq_det_prog #(.N(3), .OVERLAP(1'b1)) u_ov (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .load(load),
        .pattern(pat3), .det(det_ov), .det_cnt(cnt_ov));

    seq_det_prog #(.N(4), .OVERLAP(1'b1)) u_n4 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .load(load),
        .pattern(pat4), .det(det_n4), .det_cnt(cnt_n4));

    seq_det_prog #(.N(2), .OVERLAP(1'b1), .PAT_INIT(2'b11), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .load(load),
        .pattern(pat2), .det(det_sat), .det_cnt(cnt_sat));

    function automatic int ec(input int v);
        return CNT_EN ? v : 0;
    endfunction

    // Drive one cycle of inputs on the falling edge, return 1 ns after the following rising edge.
    task automatic step(input logic v, input logic b, input logic ld);
        @(negedge clk);
        in_valid = v;
        inp      = b;
        load     = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        load     = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; inp = 1'b0; in_valid = 1'b0; load = 1'b0;
        pat3 = 3'b101; pat4 = 4'b1101; pat2 = 2'b11;
        #3;
        checks++;
        if ({det_no, det_ov, det_n4, det_sat} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_det: got %b want 0000", {det_no, det_ov, det_n4, det_sat});
        end
        checks++;
        if ({cnt_no, cnt_ov, cnt_n4, cnt_sat} !== 26'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d want 0", cnt_no, cnt_ov, cnt_n4, cnt_sat);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Stream 1,0,1,0,1 into both N=3 instances (pattern 101 from reset).
    task automatic test_non_overlap();
        logic [4:0] stream  = 5'b10101;
        logic [4:0] exp_det = 5'b00100;
        int         exp_c[5] = '{0, 0, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, stream[4-i], 1'b0);
            checks++;
            if (det_no !== exp_det[4-i]) begin
                errors++;
                $display("FAIL non_overlap_det bit%0d: got %b want %b", i, det_no, exp_det[4-i]);
            end
            checks++;
            if (cnt_no !== 8'(ec(exp_c[i]))) begin
                errors++;
                $display("FAIL non_overlap_cnt bit%0d: got %0d want %0d", i, cnt_no, ec(exp_c[i]));
            end
        end
    endtask

    task automatic test_overlap();
        logic [4:0] stream  = 5'b10101;
        logic [4:0] exp_det = 5'b00101;
        int         exp_c[5] = '{0, 0, 1, 1, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, stream[4-i], 1'b0);
            checks++;
            if (det_ov !== exp_det[4-i]) begin
                errors++;
                $display("FAIL overlap_det bit%0d: got %b want %b", i, det_ov, exp_det[4-i]);
            end
            checks++;
            if (cnt_ov !== 8'(ec(exp_c[i]))) begin
                errors++;
                $display("FAIL overlap_cnt bit%0d: got %0d want %0d", i, cnt_ov, ec(exp_c[i]));
            end
        end
    endtask

    // N=4, pattern 1101, two idle cycles between accepted bits; det holds across gaps.
    task automatic test_gaps();
        logic [3:0] stream  = 4'b1101;
        logic [3:0] exp_det = 4'b0001;
        do_reset();
        pat4 = 4'b1101;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, stream[3-i], 1'b0);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (det_n4 !== exp_det[3-i]) begin
                    errors++;
                    $display("FAIL gaps_det bit%0d gap%0d: got %b want %b", i, g, det_n4, exp_det[3-i]);
                end
                if (g < 2) step(1'b0, 1'b1, 1'b0);
            end
        end
        checks++;
        if (cnt_n4 !== 8'(ec(1))) begin
            errors++;
            $display("FAIL gaps_cnt: got %0d want %0d", cnt_n4, ec(1));
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (det_n4 !== 1'b0) begin
            errors++;
            $display("FAIL gaps_release: got %b want 0", det_n4);
        end
    endtask

    // Load 0110 after 1,1,0 of a 1101 match (with a coincident valid bit), then prove the new pattern is live.
    task automatic test_load_mid();
        logic [4:0] stream  = 5'b10110;
        logic [4:0] exp_det = 5'b00001;
        do_reset();
        pat4 = 4'b1101;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        pat4 = 4'b0110;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, stream[4-i], 1'b0);
            checks++;
            if (det_n4 !== exp_det[4-i]) begin
                errors++;
                $display("FAIL load_mid_det bit%0d: got %b want %b", i, det_n4, exp_det[4-i]);
            end
            if (i == 0) begin
                checks++;
                if (cnt_n4 !== 8'd0) begin
                    errors++;
                    $display("FAIL load_mid_cnt0: got %0d want 0", cnt_n4);
                end
            end
        end
        checks++;
        if (cnt_n4 !== 8'(ec(1))) begin
            errors++;
            $display("FAIL load_mid_cnt: got %0d want %0d", cnt_n4, ec(1));
        end
    endtask

    // All-zero pattern must wait for a full history before matching.
    task automatic test_zero_pattern();
        logic [3:0] exp_det = 4'b0001;
        do_reset();
        pat4 = 4'b0000;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (det_n4 !== exp_det[3-i]) begin
                errors++;
                $display("FAIL zero_pat_det bit%0d: got %b want %b", i, det_n4, exp_det[3-i]);
            end
        end
    endtask

    // Asynchronous reset while det=1 also restores PAT_INIT (101) over a loaded 110.
    task automatic test_async_reset();
        do_reset();
        pat3 = 3'b110;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (det_no !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_det: got %b want 1", det_no);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (det_no !== 1'b0 || det_ov !== 1'b0) begin
            errors++;
            $display("FAIL async_det: got %b%b want 00", det_no, det_ov);
        end
        checks++;
        if (cnt_no !== 8'd0 || cnt_ov !== 8'd0) begin
            errors++;
            $display("FAIL async_cnt: got %0d/%0d want 0", cnt_no, cnt_ov);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (det_no !== 1'b1) begin
            errors++;
            $display("FAIL async_pat_init: got %b want 1", det_no);
        end
    endtask

    // N=2 pattern 11, CW=2: six 1s saturate at 3 without wrapping.
    task automatic test_saturation();
        logic [5:0] exp_det = 6'b011111;
        int         exp_c[6] = '{0, 1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (det_sat !== exp_det[5-i]) begin
                errors++;
                $display("FAIL sat_det bit%0d: got %b want %b", i, det_sat, exp_det[5-i]);
            end
            checks++;
            if (cnt_sat !== 2'(ec(exp_c[i]))) begin
                errors++;
                $display("FAIL sat_cnt bit%0d: got %0d want %0d", i, cnt_sat, ec(exp_c[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_non_overlap();
        test_overlap();
        test_gaps();
        test_load_mid();
        test_zero_pattern();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
